// File: rtl/icb_arb_n.sv
// N-master to 1-slave ICB arbiter: round-robin cmd arbitration, in-order rsp routing
// through an outstanding-ID FIFO, and detection of responses with no outstanding cmd.
module icb_arb_n #(
    parameter int unsigned MASTERS = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned OUTS    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [MASTERS-1:0]           m_cmd_valid,
    output logic [MASTERS-1:0]           m_cmd_ready,
    input  logic [MASTERS*AW-1:0]        m_cmd_addr,
    input  logic [MASTERS-1:0]           m_cmd_we,
    input  logic [MASTERS*DW-1:0]        m_cmd_wdata,
    input  logic [MASTERS*(DW/8)-1:0]    m_cmd_wem,
    output logic [MASTERS-1:0]           m_rsp_valid,
    input  logic [MASTERS-1:0]           m_rsp_ready,
    output logic [DW-1:0]                m_rsp_rdata,
    output logic                         m_rsp_error,
    output logic                         s_cmd_valid,
    input  logic                         s_cmd_ready,
    output logic [AW-1:0]                s_cmd_addr,
    output logic                         s_cmd_we,
    output logic [DW-1:0]                s_cmd_wdata,
    output logic [DW/8-1:0]              s_cmd_wem,
    input  logic                         s_rsp_valid,
    output logic                         s_rsp_ready,
    input  logic [DW-1:0]                s_rsp_rdata,
    input  logic                         s_rsp_error,
    output logic [$clog2(OUTS):0]        outs_cnt_o,
    output logic                         unexp_rsp_o
);

    localparam int unsigned IDW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int unsigned PW  = $clog2(OUTS);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned WW  = DW / 8;

    if (MASTERS < 2 || MASTERS > 8) begin : g_bad_masters
        $error("icb_arb_n: MASTERS must be in the range 2..8");
    end
    if (OUTS < 2 || (OUTS & (OUTS - 1)) != 0) begin : g_bad_outs
        $error("icb_arb_n: OUTS must be a power of 2 and at least 2");
    end

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt;
    logic           any_req;
    logic [IDW-1:0] id_mem [OUTS];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] head;
    logic           full;
    logic           empty;
    logic           cmd_hs;
    logic           rsp_hs;

    // Rotate the request vector so the scan always starts at rr_ptr
    always_comb begin : arb_c
        logic [2*MASTERS-1:0] req_rot;
        int unsigned          sum;
        req_rot = {m_cmd_valid, m_cmd_valid} >> rr_ptr;
        sum     = 0;
        gnt     = '0;
        any_req = 1'b0;
        for (int unsigned k = 0; k < MASTERS; k++) begin
            if (!any_req && req_rot[k]) begin
                any_req = 1'b1;
                sum     = 32'(rr_ptr) + k;
                if (sum >= MASTERS) begin
                    sum = sum - MASTERS;
                end
                gnt = IDW'(sum);
            end
        end
    end

    // Granted master's fields drive the slave cmd channel
    always_comb begin : cmd_mux_c
        s_cmd_addr  = '0;
        s_cmd_we    = 1'b0;
        s_cmd_wdata = '0;
        s_cmd_wem   = '0;
        for (int unsigned i = 0; i < MASTERS; i++) begin
            if (gnt == IDW'(i)) begin
                s_cmd_addr  = m_cmd_addr[i*AW +: AW];
                s_cmd_we    = m_cmd_we[i];
                s_cmd_wdata = m_cmd_wdata[i*DW +: DW];
                s_cmd_wem   = m_cmd_wem[i*WW +: WW];
            end
        end
    end

    assign full        = (cnt == CW'(OUTS));
    assign empty       = (cnt == '0);
    assign head        = id_mem[rd_ptr];
    assign s_cmd_valid = rst_n & any_req & ~full;
    assign cmd_hs      = s_cmd_valid & s_cmd_ready;
    assign s_rsp_ready = rst_n & (empty | m_rsp_ready[head]);
    assign rsp_hs      = s_rsp_valid & s_rsp_ready & ~empty;
    assign m_rsp_rdata = s_rsp_rdata;
    assign m_rsp_error = s_rsp_error;
    assign outs_cnt_o  = cnt;

    // One-hot ready to the granted master, rsp valid to the FIFO head
    always_comb begin : onehot_c
        m_cmd_ready = '0;
        m_rsp_valid = '0;
        for (int unsigned i = 0; i < MASTERS; i++) begin
            m_cmd_ready[i] = cmd_hs & (gnt == IDW'(i));
            m_rsp_valid[i] = rst_n & ~empty & s_rsp_valid & (head == IDW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            unexp_rsp_o <= 1'b0;
        end else begin
            unexp_rsp_o <= s_rsp_valid & empty;
            if (cmd_hs) begin
                rr_ptr <= (gnt == IDW'(MASTERS - 1)) ? '0 : gnt + IDW'(1);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rsp_hs) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({cmd_hs, rsp_hs})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // ID storage needs no reset; only entries between rd_ptr and wr_ptr are ever read
    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            id_mem[wr_ptr] <= gnt;
        end
    end

endmodule

// File: tb/tb_icb_arb_n.sv
// Randomized bench for icb_arb_n: queue-based reference of the arbiter, a bench slave,
// and a separate response monitor that pops expected responses from a scoreboard.
module tb_icb_arb_n;

    localparam int unsigned M    = 3;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned WW   = DW / 8;
    localparam int unsigned OUTS = 4;
    localparam int unsigned CW   = $clog2(OUTS) + 1;

    logic              clk;
    logic              rst_n;
    logic [M-1:0]      m_cmd_valid;
    logic [M-1:0]      m_cmd_ready;
    logic [M*AW-1:0]   m_cmd_addr;
    logic [M-1:0]      m_cmd_we;
    logic [M*DW-1:0]   m_cmd_wdata;
    logic [M*WW-1:0]   m_cmd_wem;
    logic [M-1:0]      m_rsp_valid;
    logic [M-1:0]      m_rsp_ready;
    logic [DW-1:0]     m_rsp_rdata;
    logic              m_rsp_error;
    logic              s_cmd_valid;
    logic              s_cmd_ready;
    logic [AW-1:0]     s_cmd_addr;
    logic              s_cmd_we;
    logic [DW-1:0]     s_cmd_wdata;
    logic [WW-1:0]     s_cmd_wem;
    logic              s_rsp_valid;
    logic              s_rsp_ready;
    logic [DW-1:0]     s_rsp_rdata;
    logic              s_rsp_error;
    logic [CW-1:0]     outs_cnt_o;
    logic              unexp_rsp_o;

    icb_arb_n #(.MASTERS(M), .AW(AW), .DW(DW), .OUTS(OUTS)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
        .m_cmd_we(m_cmd_we), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wem(m_cmd_wem),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_error(m_rsp_error),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_addr(s_cmd_addr),
        .s_cmd_we(s_cmd_we), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wem(s_cmd_wem),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_error(s_rsp_error),
        .outs_cnt_o(outs_cnt_o), .unexp_rsp_o(unexp_rsp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned   mst;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_rsp_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } slv_rsp_t;

    int checks = 0;
    int errors = 0;

    // Reference state: outstanding master IDs in issue order and the round-robin start
    int unsigned mdl_q[$];
    int unsigned rr = 0;
    logic        exp_unexp = 1'b0;
    exp_rsp_t    exp_q[$];
    slv_rsp_t    slv_q[$];

    // Master-side pending commands
    logic          pend    [M];
    logic [AW-1:0] c_addr  [M];
    logic          c_we    [M];
    logic [DW-1:0] c_wdata [M];
    logic [WW-1:0] c_wem   [M];

    // Bench slave response currently presented
    logic          sr_busy = 1'b0;
    logic          sr_real = 1'b0;
    logic [DW-1:0] sr_data = '0;
    logic          sr_err  = 1'b0;

    // Stimulus knobs (percentages)
    logic [M-1:0] en_mask = '0;
    int unsigned  p_valid = 0, p_sready = 0, p_rsp = 0, p_mready = 0, p_unexp = 0;

    int unsigned gq[$];
    logic        rec_grants = 1'b0;
    int          full_hits = 0, unexp_hits = 0, rsp_seen = 0, mid_resets = 0;

    function automatic logic [DW-1:0] rsp_data(input logic [AW-1:0] a, input logic [DW-1:0] wd);
        return a ^ {wd[15:0], wd[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic rsp_err(input logic [AW-1:0] a, input logic we, input logic [WW-1:0] wem);
        return (^wem) ^ we ^ a[2];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < M; i++) begin
            if (!pend[i] && en_mask[i] && $urandom_range(99, 0) < p_valid) begin
                pend[i]    = 1'b1;
                c_addr[i]  = $urandom;
                c_we[i]    = 1'($urandom);
                c_wdata[i] = $urandom;
                c_wem[i]   = WW'($urandom);
            end
            m_cmd_valid[i]           = pend[i];
            m_cmd_addr[i*AW +: AW]   = c_addr[i];
            m_cmd_we[i]              = c_we[i];
            m_cmd_wdata[i*DW +: DW]  = c_wdata[i];
            m_cmd_wem[i*WW +: WW]    = c_wem[i];
            m_rsp_ready[i]           = ($urandom_range(99, 0) < p_mready);
        end
        s_cmd_ready = ($urandom_range(99, 0) < p_sready);
        if (!sr_busy) begin
            if (slv_q.size() > 0 && $urandom_range(99, 0) < p_rsp) begin
                sr_busy = 1'b1;
                sr_real = 1'b1;
                sr_data = slv_q[0].rdata;
                sr_err  = slv_q[0].err;
            end else if (slv_q.size() == 0 && mdl_q.size() == 0 &&
                         $urandom_range(99, 0) < p_unexp) begin
                sr_busy = 1'b1;
                sr_real = 1'b0;
                sr_data = $urandom;
                sr_err  = 1'($urandom);
            end
        end
        s_rsp_valid = sr_busy;
        s_rsp_rdata = sr_data;
        s_rsp_error = sr_err;
    endtask

    // Compare DUT against the reference for this cycle, then advance the reference
    task automatic check_cycle();
        logic        full, any, pop;
        int unsigned g, h, idx;
        logic [M-1:0] e_mr, e_mrv;
        logic        e_srr;
        if (!rst_n) begin
            chk("rst_s_cmd_valid", 64'(s_cmd_valid), 0);
            chk("rst_m_cmd_ready", 64'(m_cmd_ready), 0);
            chk("rst_m_rsp_valid", 64'(m_rsp_valid), 0);
            chk("rst_s_rsp_ready", 64'(s_rsp_ready), 0);
            chk("rst_outs_cnt", 64'(outs_cnt_o), 0);
            chk("rst_unexp", 64'(unexp_rsp_o), 0);
            mdl_q.delete();
            exp_q.delete();
            slv_q.delete();
            sr_real   = 1'b0;
            rr        = 0;
            exp_unexp = 1'b0;
            return;
        end
        chk("unexp_rsp", 64'(unexp_rsp_o), 64'(exp_unexp));
        if (exp_unexp) unexp_hits++;
        chk("outs_cnt", 64'(outs_cnt_o), 64'(mdl_q.size()));
        full = (mdl_q.size() == OUTS);
        any  = 1'b0;
        g    = 0;
        for (int k = 0; k < M; k++) begin
            idx = (rr + k) % M;
            if (!any && m_cmd_valid[idx]) begin
                any = 1'b1;
                g   = idx;
            end
        end
        if (full && any) full_hits++;
        e_mr = (any && !full && s_cmd_ready) ? M'(1 << g) : '0;
        chk("s_cmd_valid", 64'(s_cmd_valid), 64'(any && !full));
        chk("m_cmd_ready", 64'(m_cmd_ready), 64'(e_mr));
        h = (mdl_q.size() > 0) ? mdl_q[0] : 0;
        if (mdl_q.size() > 0) begin
            e_mrv = s_rsp_valid ? M'(1 << h) : '0;
            e_srr = m_rsp_ready[h];
        end else begin
            e_mrv = '0;
            e_srr = 1'b1;
        end
        chk("m_rsp_valid", 64'(m_rsp_valid), 64'(e_mrv));
        chk("s_rsp_ready", 64'(s_rsp_ready), 64'(e_srr));
        if (s_rsp_valid) begin
            chk("rsp_rdata_pass", 64'(m_rsp_rdata), 64'(s_rsp_rdata));
            chk("rsp_error_pass", 64'(m_rsp_error), 64'(s_rsp_error));
        end
        pop = s_rsp_valid && mdl_q.size() > 0 && m_rsp_ready[h];
        exp_unexp = s_rsp_valid && mdl_q.size() == 0;
        // Bench slave reacts to what the DUT actually did on its ports
        if (s_rsp_valid && s_rsp_ready) begin
            if (sr_real && slv_q.size() > 0) void'(slv_q.pop_front());
            sr_busy = 1'b0;
        end
        if (s_cmd_valid && s_cmd_ready)
            slv_q.push_back('{rsp_data(s_cmd_addr, s_cmd_wdata),
                              rsp_err(s_cmd_addr, s_cmd_we, s_cmd_wem)});
        if (pop) void'(mdl_q.pop_front());
        if (|e_mr) begin
            chk("s_cmd_addr", 64'(s_cmd_addr), 64'(c_addr[g]));
            chk("s_cmd_we", 64'(s_cmd_we), 64'(c_we[g]));
            chk("s_cmd_wdata", 64'(s_cmd_wdata), 64'(c_wdata[g]));
            chk("s_cmd_wem", 64'(s_cmd_wem), 64'(c_wem[g]));
            mdl_q.push_back(g);
            exp_q.push_back('{g, rsp_data(c_addr[g], c_wdata[g]),
                              rsp_err(c_addr[g], c_we[g], c_wem[g])});
            rr      = (g + 1) % M;
            pend[g] = 1'b0;
            if (rec_grants) gq.push_back(g);
        end
    endtask

    task automatic do_cycle(input logic rst_pulse);
        @(negedge clk);
        rst_n = !rst_pulse;
        drive();
        #2;
        check_cycle();
    endtask

    task automatic set_knobs(input logic [M-1:0] en, input int unsigned pv, input int unsigned ps,
                             input int unsigned pr, input int unsigned pm, input int unsigned pu);
        en_mask = en; p_valid = pv; p_sready = ps; p_rsp = pr; p_mready = pm; p_unexp = pu;
    endtask

    // Response monitor: every delivered response must match the oldest issued cmd
    initial begin
        exp_rsp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                for (int i = 0; i < M; i++) begin
                    if (m_rsp_valid[i] && m_rsp_ready[i]) begin
                        rsp_seen++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rsp_no_expected: master %0d got a response, expected none", i);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rsp_master", 64'(i), 64'(e.mst));
                            chk("rsp_rdata", 64'(m_rsp_rdata), 64'(e.rdata));
                            chk("rsp_error", 64'(m_rsp_error), 64'(e.err));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic rst_req;
        rst_n       = 1'b0;
        m_cmd_valid = '0;
        m_cmd_addr  = '0;
        m_cmd_we    = '0;
        m_cmd_wdata = '0;
        m_cmd_wem   = '0;
        m_rsp_ready = '0;
        s_cmd_ready = 1'b0;
        s_rsp_valid = 1'b0;
        s_rsp_rdata = '0;
        s_rsp_error = 1'b0;
        for (int i = 0; i < M; i++) begin
            pend[i] = 1'b0; c_addr[i] = '0; c_we[i] = 1'b0; c_wdata[i] = '0; c_wem[i] = '0;
        end

        for (int n = 0; n < 3; n++) do_cycle(1'b1);
        // Unexpected responses with nothing outstanding
        set_knobs(3'b000, 0, 100, 0, 100, 40);
        for (int n = 0; n < 40; n++) do_cycle(1'b0);
        set_knobs(3'b000, 0, 100, 0, 100, 0);
        for (int n = 0; n < 4; n++) do_cycle(1'b0);
        // Single master traffic
        set_knobs(3'b001, 60, 70, 50, 80, 0);
        for (int n = 0; n < 200; n++) do_cycle(1'b0);
        // Two masters always requesting must alternate
        set_knobs(3'b011, 100, 100, 100, 100, 0);
        for (int n = 0; n < 10; n++) do_cycle(1'b0);
        rec_grants = 1'b1;
        for (int n = 0; n < 12; n++) do_cycle(1'b0);
        rec_grants = 1'b0;
        chk("fair_grant_count", 64'(gq.size() >= 6), 1);
        if (gq.size() >= 6)
            for (int k = 1; k < 6; k++) chk("fair_alternate", 64'(gq[k]), 64'(1 - gq[k-1]));
        // Fill the ID FIFO, hold it full, then drain
        set_knobs(3'b111, 100, 100, 0, 100, 0);
        for (int n = 0; n < 30; n++) do_cycle(1'b0);
        chk("fifo_reached_full", 64'(outs_cnt_o), 64'(OUTS));
        set_knobs(3'b111, 100, 100, 100, 100, 0);
        for (int n = 0; n < 30; n++) do_cycle(1'b0);
        // Random mix with occasional mid-transaction resets at three outstanding
        set_knobs(3'b111, 50, 60, 40, 70, 20);
        rst_req = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            do_cycle(rst_req);
            rst_req = (!rst_req && mdl_q.size() == 3 && mid_resets < 3);
            if (rst_req) mid_resets++;
        end
        do_cycle(1'b0);
        do_cycle(1'b0);

        chk("full_blocking_seen", 64'(full_hits > 0), 1);
        chk("unexp_pulse_seen", 64'(unexp_hits > 0), 1);
        chk("mid_reset_seen", 64'(mid_resets > 0), 1);
        chk("responses_seen", 64'(rsp_seen > 100), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
